// File: rtl/feeder_pkg.sv
// Shared types and helpers for the systolic-array activation feeder.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_e;

    // $clog2 that never returns 0, so counters/pointers are at least 1 bit wide.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned MIN_IDX_W = clog2_safe(1);

endpackage

// File: rtl/skew_lane.sv
// One activation lane: stage-0 register plus (N_REGS-1) delay registers, all
// advancing together on i_en.
module skew_lane #(
    parameter int unsigned N_REGS = 1,
    parameter int unsigned I_W    = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clear,
    input  logic           i_en,
    input  logic [I_W-1:0] i_din,
    output logic [I_W-1:0] o_dout
);

    logic [I_W-1:0] stage_q [N_REGS];
    logic [I_W-1:0] stage_d [N_REGS];

    always_comb begin
        stage_d = stage_q;
        if (i_en) begin
            stage_d[0] = i_din;
            for (int unsigned i = 1; i < N_REGS; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_dout = stage_q[N_REGS-1];

endmodule

// File: rtl/ifmap_skew_feeder.sv
// Activation feeder: shared Y-lane FIFO, row masking, diagonal skew, context
// FSM with drain/done signalling and a starvation watchdog.
module ifmap_skew_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned Y     = 3,
    parameter int unsigned IA_W  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WD_W  = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_final,
    input  logic [0:Y-1]              i_rows_active,
    input  logic                      i_push_valid,
    input  logic [0:Y-1][IA_W-1:0]    i_push_data,
    output logic                      o_push_ready,
    input  logic                      i_pipeline_en,
    input  logic [WD_W-1:0]           i_wd_limit,
    output logic [0:Y-1][IA_W-1:0]    o_a_arr,
    output logic                      o_fifo_empty,
    output logic                      o_fifo_full,
    output logic [CNT_W-1:0]          o_count,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_deadlock
);

    localparam int unsigned PTR_W      = clog2_safe(DEPTH);
    localparam int unsigned DR_W       = clog2_safe(Y);
    localparam int unsigned DRAIN_LAST = (Y > 1) ? (Y - 2) : 0;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    feed_state_e state_q, state_d;

    logic [0:Y-1][IA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             final_pending_q, final_pending_d;
    logic [DR_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             deadlock_q, deadlock_d;

    logic             restart, fifo_empty, fifo_full, push_ready;
    logic             push_fire, pop, starved;
    logic [IA_W-1:0]  lane_din [Y];

    always_comb begin
        restart    = i_start && (state_q != IDLE);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        push_ready = !fifo_full && !final_pending_q && (state_q == IDLE || state_q == RUN);
        push_fire  = i_push_valid && push_ready && !restart;
        pop        = (state_q == RUN) && i_pipeline_en && !fifo_empty && !restart;
        starved    = (state_q == RUN) && i_pipeline_en && fifo_empty && !final_pending_q;

        // Row mask is applied here, at pop time, so it only affects newly popped words.
        for (int unsigned j = 0; j < Y; j++) begin
            lane_din[j] = (pop && i_rows_active[j]) ? mem_q[rd_ptr_q][j] : '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (restart) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_fire) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
            if (pop)       rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            unique case ({push_fire, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d         = state_q;
        final_pending_d = final_pending_q;
        drain_cnt_d     = drain_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) state_d = RUN;
            end
            RUN: begin
                if (final_pending_q && fifo_empty) begin
                    state_d     = (Y == 1) ? DONE : DRAIN;
                    drain_cnt_d = '0;
                end
                if (i_final) final_pending_d = 1'b1;
            end
            DRAIN: begin
                if (i_pipeline_en) begin
                    if (drain_cnt_q == DR_W'(DRAIN_LAST)) begin
                        state_d = DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d         = IDLE;
                final_pending_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d         = RUN;
            final_pending_d = 1'b0;
            drain_cnt_d     = '0;
        end
    end

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (restart || state_q != RUN || pop || push_fire) begin
            wd_cnt_d = '0;
        end else if (starved && wd_cnt_q != '1) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        deadlock_d = deadlock_q;
        if (i_start) begin
            deadlock_d = 1'b0;
        end else if (i_wd_limit != '0 && state_q == RUN && wd_cnt_d >= i_wd_limit) begin
            deadlock_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            final_pending_q <= 1'b0;
            drain_cnt_q     <= '0;
            wd_cnt_q        <= '0;
            deadlock_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            final_pending_q <= final_pending_d;
            drain_cnt_q     <= drain_cnt_d;
            wd_cnt_q        <= wd_cnt_d;
            deadlock_q      <= deadlock_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= i_push_data;
    end

    for (genvar j = 0; j < Y; j++) begin : g_lane
        skew_lane #(
            .N_REGS(j + 1),
            .I_W   (IA_W)
        ) u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_clear(restart),
            .i_en   (i_pipeline_en),
            .i_din  (lane_din[j]),
            .o_dout (o_a_arr[j])
        );
    end

    assign o_push_ready = push_ready;
    assign o_fifo_empty = fifo_empty;
    assign o_fifo_full  = fifo_full;
    assign o_count      = count_q;
    assign o_busy       = (state_q == RUN) || (state_q == DRAIN);
    assign o_done       = (state_q == DONE);
    assign o_deadlock   = deadlock_q;

endmodule
